activation_stream_int8: RTL and testbench

// Streaming, multi-lane INT8 activation engine: ReLU / ReLU6 / LeakyReLU / pass-through.
// It is the consumer/producer counterpart of the combinational activation cells.

---
 rtl/activation_stream_int8.sv | 89 ++++++++
 tb/tb_activation_stream_int8.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_stream_int8.sv
// activation_stream_int8: streaming multi-lane INT8 activation (pass/ReLU/ReLU6/LeakyReLU)
//   clk, rst_n           clock, asynchronous active-low reset
//   cfg_mode[1:0]        0=pass 1=relu 2=relu6 3=leaky, latched at packet start
//   s_valid/s_ready      input beat handshake; s_data lanes, s_last ends packet
//   m_valid/m_ready      output beat handshake; m_data activated lanes, m_last follows its beat
//   busy                 packet open or any pipeline stage occupied
//   beat_count[15:0]     output handshakes since reset, wrapping
module activation_stream_int8 #(
    parameter int LANES       = 4,
    parameter int RELU6_MAX   = 6,
    parameter int LEAKY_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         cfg_mode,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [8*LANES-1:0] s_data,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [8*LANES-1:0] m_data,
    output logic               m_last,
    output logic               busy,
    output logic [15:0]        beat_count
);
    typedef enum logic {IDLE, IN_PKT} state_t;
    localparam logic signed [7:0] R6 = 8'(RELU6_MAX);
    state_t             state_q, state_d;
    logic [1:0]         pkt_mode_q, pkt_mode_d, mode1_q, mode1_d, beat_mode;
    logic               v1_q, v1_d, v2_q, v2_d, last1_q, last1_d, last2_q, last2_d;
    logic [8*LANES-1:0] d1_q, d1_d, d2_q, d2_d, act;
    logic [15:0]        cnt_q, cnt_d;
    logic               adv2, accept;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [7:0] x;
        assign x = d1_q[8*i +: 8];
        assign act[8*i +: 8] = mode1_q == 2'd0 ? x :
                               !x[7] ? ((mode1_q == 2'd2 && x > R6) ? R6 : x) :
                               mode1_q == 2'd3 ? (x >>> LEAKY_SHIFT) : 8'sd0;
    end
    // S2 may load when empty or draining; S1 may load when empty or moving into S2
    always_comb begin
        adv2       = !v2_q || m_ready;
        s_ready    = !v1_q || adv2;
        accept     = s_valid && s_ready;
        beat_mode  = state_q == IDLE ? cfg_mode : pkt_mode_q;
        v1_d       = s_ready ? s_valid : v1_q;
        d1_d       = accept ? s_data : d1_q;
        last1_d    = accept ? s_last : last1_q;
        mode1_d    = accept ? beat_mode : mode1_q;
        v2_d       = adv2 ? v1_q : v2_q;
        d2_d       = (adv2 && v1_q) ? act : d2_q;
        last2_d    = (adv2 && v1_q) ? last1_q : last2_q;
        pkt_mode_d = (accept && state_q == IDLE) ? cfg_mode : pkt_mode_q;
        state_d    = accept ? (s_last ? IDLE : IN_PKT) : state_q;
        cnt_d      = cnt_q + 16'(v2_q && m_ready);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pkt_mode_q <= '0;
            mode1_q    <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            last1_q    <= 1'b0;
            last2_q    <= 1'b0;
            d1_q       <= '0;
            d2_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pkt_mode_q <= pkt_mode_d;
            mode1_q    <= mode1_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            last1_q    <= last1_d;
            last2_q    <= last2_d;
            d1_q       <= d1_d;
            d2_q       <= d2_d;
            cnt_q      <= cnt_d;
        end
    end
    assign m_valid    = v2_q;
    assign m_data     = d2_q;
    assign m_last     = last2_q;
    assign busy       = state_q == IN_PKT || v1_q || v2_q;
    assign beat_count = cnt_q;
endmodule

// File: tb/tb_activation_stream_int8.sv
// tb_activation_stream_int8: scoreboard bench for activation_stream_int8
module tb_activation_stream_int8;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic        s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
    logic [31:0] s_data = '0;
    logic        s_ready, m_valid, m_last, busy;
    logic [31:0] m_data;
    logic [15:0] beat_count;
    int          vectors = 0, errors = 0;
    logic [32:0] sb[$];
    logic [31:0] seen[$];
    logic        in_pkt = 1'b0, stall_prev = 1'b0;
    logic [1:0]  pm = 2'd0, bm;
    logic [32:0] prev_out, exp_v;

    activation_stream_int8 dut (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last), .busy(busy), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [7:0] act8(input logic [7:0] x, input logic [1:0] m);
        int v = $signed(x);
        case (m)
            2'd0: return x;
            2'd1: return v < 0 ? 8'd0 : x;
            2'd2: return v < 0 ? 8'd0 : (v > 6 ? 8'd6 : x);
            default: return v < 0 ? 8'(v / 4 - ((v % 4 != 0) ? 1 : 0)) : x;
        endcase
    endfunction

    function automatic logic [31:0] act32(input logic [31:0] d, input logic [1:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = act8(d[8*i +: 8], m);
        return r;
    endfunction

    // Scoreboard: model pushes on input handshake, compare pops on output handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            in_pkt = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                vectors++;
                if ({m_last, m_data} !== prev_out) begin
                    errors++;
                    $display("FAIL stall_hold got %h want %h", {m_last, m_data}, prev_out);
                end
            end
            if (m_valid && m_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out got %h want none", {m_last, m_data});
                end else begin
                    exp_v = sb.pop_front();
                    if ({m_last, m_data} !== exp_v) begin
                        errors++;
                        $display("FAIL sb_data got %h want %h", {m_last, m_data}, exp_v);
                    end
                end
                seen.push_back(m_data);
            end
            stall_prev = m_valid && !m_ready;
            prev_out = {m_last, m_data};
            if (s_valid && s_ready) begin
                bm = in_pkt ? pm : cfg_mode;
                if (!in_pkt) pm = cfg_mode;
                in_pkt = !s_last;
                sb.push_back({s_last, act32(s_data, bm)});
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic l, input logic [1:0] m);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_last = l; cfg_mode = m;
        @(negedge clk);
        while (!s_ready) begin
            if (++n > 500) begin
                $display("FAIL send_timeout s_ready stuck low");
                $fatal(1);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy || sb.size() != 0) begin
            @(negedge clk);
            if (++n > 1000) begin
                $display("FAIL drain_timeout busy=%0b pending=%0d", busy, sb.size());
                $fatal(1);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(negedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL por_m_valid got %b want 0", m_valid); end
        vectors++; if (m_data !== 32'h0) begin errors++; $display("FAIL por_m_data got %h want 0", m_data); end
        vectors++; if (m_last !== 1'b0) begin errors++; $display("FAIL por_m_last got %b want 0", m_last); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL por_busy got %b want 0", busy); end
        vectors++; if (beat_count !== 16'd0) begin errors++; $display("FAIL por_count got %0d want 0", beat_count); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_valid = 1'b1; s_data = 32'h7F01_80FF; s_last = 1'b0; cfg_mode = 2'd0;
        repeat (4) @(posedge clk);
        #3;
        vectors++; if (beat_count !== 16'd2) begin errors++; $display("FAIL pre_rst_count got %0d want 2", beat_count); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL pre_rst_busy got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
        vectors++; if (m_data !== 32'h0) begin errors++; $display("FAIL rst_m_data got %h want 0", m_data); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        vectors++; if (beat_count !== 16'd0) begin errors++; $display("FAIL rst_count got %0d want 0", beat_count); end
        s_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_relu();
        send(32'h80_00_FD_05, 1'b1, 2'd1);
        vectors++; if (m_valid !== 1'b0) begin errors++; $display("FAIL relu_early got %b want 0", m_valid); end
        @(posedge clk); #1;
        vectors++; if (m_valid !== 1'b1) begin errors++; $display("FAIL relu_valid got %b want 1", m_valid); end
        vectors++; if (m_data !== 32'h0000_0005) begin errors++; $display("FAIL relu_data got %h want 00000005", m_data); end
        vectors++; if (m_last !== 1'b1) begin errors++; $display("FAIL relu_last got %b want 1", m_last); end
        wait_idle();
    endtask

    task automatic test_mode_switch();
        seen.delete();
        send(32'h00_FE_05_07, 1'b0, 2'd2);
        send(32'h00_FE_05_07, 1'b0, 2'd3);
        send(32'h00_FE_05_07, 1'b1, 2'd3);
        send(32'h80_FD_08_F8, 1'b1, 2'd3);
        wait_idle();
        vectors++;
        if (seen.size() != 4) begin
            errors++; $display("FAIL switch_count got %0d want 4", seen.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (seen[k] !== 32'h0000_0506) begin errors++; $display("FAIL switch_beat%0d got %h want 00000506", k, seen[k]); end
            end
            vectors++;
            if (seen[3] !== 32'hE0FF_08FE) begin errors++; $display("FAIL leaky_pkt got %h want e0ff08fe", seen[3]); end
        end
    endtask

    task automatic test_boundaries();
        seen.delete();
        send(32'h80_7F_07_06, 1'b1, 2'd2);
        send(32'hFC_7F_80_FF, 1'b1, 2'd3);
        send(32'h80_7F_01_FF, 1'b1, 2'd0);
        wait_idle();
        vectors++;
        if (seen.size() != 3) begin
            errors++; $display("FAIL bound_count got %0d want 3", seen.size());
        end else begin
            vectors++; if (seen[0] !== 32'h0006_0606) begin errors++; $display("FAIL relu6_clamp got %h want 00060606", seen[0]); end
            vectors++; if (seen[1] !== 32'hFF7F_E0FF) begin errors++; $display("FAIL leaky_edge got %h want ff7fe0ff", seen[1]); end
            vectors++; if (seen[2] !== 32'h807F_01FF) begin errors++; $display("FAIL pass got %h want 807f01ff", seen[2]); end
        end
    endtask

    task automatic test_backpressure();
        reset_pulse();
        seen.delete();
        m_ready = 1'b0;
        fork
            for (int k = 0; k < 8; k++) send($urandom, k == 7, 2'd1);
            begin
                int n = 0;
                repeat (4) @(posedge clk);
                @(negedge clk);
                vectors++; if (s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready got %b want 0", s_ready); end
                vectors++; if (m_valid !== 1'b1) begin errors++; $display("FAIL full_m_valid got %b want 1", m_valid); end
                @(posedge clk); #1;
                while (seen.size() < 8 && n < 500) begin
                    m_ready = 1'($urandom_range(0, 1));
                    n++;
                    @(posedge clk); #1;
                end
                m_ready = 1'b1;
            end
        join
        wait_idle();
        vectors++; if (seen.size() != 8) begin errors++; $display("FAIL bp_count got %0d want 8", seen.size()); end
        vectors++; if (beat_count !== 16'd8) begin errors++; $display("FAIL bp_beat_count got %0d want 8", beat_count); end
    endtask

    task automatic test_wrap();
        int gaps = 0;
        reset_pulse();
        m_ready = 1'b1;
        fork
            begin
                s_valid = 1'b1;
                for (int k = 0; k < 65537; k++) begin
                    s_data = $urandom;
                    s_last = (k % 16 == 15) || (k == 65536);
                    cfg_mode = 2'($urandom_range(0, 3));
                    @(posedge clk); #1;
                end
                s_valid = 1'b0;
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!m_valid && n < 20) begin n++; @(negedge clk); end
                for (int k = 0; k < 65537; k++) begin
                    if (!m_valid) gaps++;
                    @(negedge clk);
                end
            end
        join
        wait_idle();
        vectors++; if (gaps != 0) begin errors++; $display("FAIL stream_gaps got %0d want 0", gaps); end
        vectors++; if (beat_count !== 16'd1) begin errors++; $display("FAIL wrap_count got %0d want 1", beat_count); end
    endtask

    initial begin
        test_reset();
        test_relu();
        test_mode_switch();
        test_boundaries();
        test_backpressure();
        test_wrap();
        vectors++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
